apb_uart_slave_if: RTL and testbench

- APB3 slave front-end that sits directly upstream of apb_uart.
- Decodes PSEL/PENABLE/PWRITE/PADDR into the core's one-hot strobes: TX_detect, RX_detect, config_write_detect, config_read_detect.
- Holds the strobe until the core's ready, then completes the APB transfer with PREADY/PSLVERR/PRDATA.
- Provides the stable, registered address/data the core expects, plus protocol-error handling the core lacks.

---
 rtl/apb_uart_slave_if.sv | 176 +++++++++++++++++
 tb/tb_apb_uart_slave_if.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_slave_if.sv
// APB3 slave front-end for apb_uart: turns APB transfers into one-hot core strobes and
// completes them on core ready. Define APB_UART_TIMEOUT_EN to add a DRIVE-state watchdog.
module apb_uart_slave_if #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] TX_ADDR        = 'h00,
  parameter logic [ADDR_WIDTH-1:0] RX_ADDR        = 'h04,
  parameter logic [ADDR_WIDTH-1:0] BAUD_ADDR      = 'h08,
  parameter logic [ADDR_WIDTH-1:0] FRAME_ADDR     = 'h0C,
  parameter logic [ADDR_WIDTH-1:0] PARITY_ADDR    = 'h10,
  parameter logic [ADDR_WIDTH-1:0] SBITS_ADDR     = 'h14,
  parameter int                    TIMEOUT_CYCLES = 1000000
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] write_data_in,
  output logic [ADDR_WIDTH-1:0] config_address,
  output logic                  TX_detect,
  output logic                  RX_detect,
  output logic                  config_write_detect,
  output logic                  config_read_detect,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ready,
  input  logic                  error
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP, ERR_RESP} state_t;

  typedef struct packed {
    logic tx;
    logic rx;
    logic cfg_wr;
    logic cfg_rd;
  } det_t;

  state_t                r_state, w_nxt_state;
  det_t                  r_det, w_nxt_det;
  logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_nxt_wdata;
  logic [DATA_WIDTH-1:0] r_prdata, w_nxt_prdata;
  logic                  r_pready, w_nxt_pready;
  logic                  r_pslverr, w_nxt_pslverr;
  logic                  r_first, w_nxt_first;
  logic                  w_access, w_is_tx, w_is_rx, w_is_cfg;

`ifdef APB_UART_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] r_cnt, w_nxt_cnt;
`else
  // The timeout limit only matters when the watchdog is compiled in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign w_access = PSEL & PENABLE & ~r_pready;
  assign w_is_tx  = (PADDR == TX_ADDR);
  assign w_is_rx  = (PADDR == RX_ADDR);
  assign w_is_cfg = (PADDR == BAUD_ADDR) | (PADDR == FRAME_ADDR) |
                    (PADDR == PARITY_ADDR) | (PADDR == SBITS_ADDR);

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_det     = r_det;
    w_nxt_addr    = r_addr;
    w_nxt_wdata   = r_wdata;
    w_nxt_prdata  = '0;
    w_nxt_pready  = 1'b0;
    w_nxt_pslverr = 1'b0;
    w_nxt_first   = 1'b0;
`ifdef APB_UART_TIMEOUT_EN
    w_nxt_cnt     = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_nxt_addr  = PADDR;
          w_nxt_wdata = PWDATA;
          w_nxt_det   = '0;
          w_nxt_first = 1'b1;
`ifdef APB_UART_TIMEOUT_EN
          w_nxt_cnt   = '0;
`endif
          if (PWRITE && w_is_tx) begin
            w_nxt_det.tx = 1'b1;
            w_nxt_state  = DRIVE;
          end else if (!PWRITE && w_is_rx) begin
            w_nxt_det.rx = 1'b1;
            w_nxt_state  = DRIVE;
          end else if (w_is_cfg) begin
            w_nxt_det.cfg_wr = PWRITE;
            w_nxt_det.cfg_rd = ~PWRITE;
            w_nxt_state      = DRIVE;
          end else begin
            w_nxt_pready  = 1'b1;
            w_nxt_pslverr = 1'b1;
            w_nxt_state   = ERR_RESP;
          end
        end
      end
      DRIVE: begin
        // The core's ready lags the strobe by a cycle, so the first DRIVE edge ignores it.
        if (!PSEL) begin
          w_nxt_det   = '0;
          w_nxt_state = IDLE;
        end else if (!r_first && ready) begin
          w_nxt_det     = '0;
          w_nxt_pready  = 1'b1;
          w_nxt_pslverr = error;
          w_nxt_prdata  = (r_det.rx | r_det.cfg_rd) ? read_data : '0;
          w_nxt_state   = RESP;
        end
`ifdef APB_UART_TIMEOUT_EN
        else if (r_cnt == TO_LAST) begin
          w_nxt_det     = '0;
          w_nxt_pready  = 1'b1;
          w_nxt_pslverr = 1'b1;
          w_nxt_state   = RESP;
        end else begin
          w_nxt_cnt = r_cnt + 24'd1;
        end
`endif
      end
      RESP, ERR_RESP: w_nxt_state = IDLE;
      default:        w_nxt_state = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_det     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_first   <= 1'b0;
`ifdef APB_UART_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_det     <= w_nxt_det;
      r_addr    <= w_nxt_addr;
      r_wdata   <= w_nxt_wdata;
      r_prdata  <= w_nxt_prdata;
      r_pready  <= w_nxt_pready;
      r_pslverr <= w_nxt_pslverr;
      r_first   <= w_nxt_first;
`ifdef APB_UART_TIMEOUT_EN
      r_cnt     <= w_nxt_cnt;
`endif
    end
  end

  assign PRDATA              = r_prdata;
  assign PREADY              = r_pready;
  assign PSLVERR             = r_pslverr;
  assign write_data_in       = r_wdata;
  assign config_address      = r_addr;
  assign TX_detect           = r_det.tx;
  assign RX_detect           = r_det.rx;
  assign config_write_detect = r_det.cfg_wr;
  assign config_read_detect  = r_det.cfg_rd;

endmodule

// File: tb/tb_apb_uart_slave_if.sv
// Directed self-checking bench for apb_uart_slave_if; the core side is driven by hand.
// With APB_UART_TIMEOUT_EN defined the watchdog case replaces the long-wait TX case.
module tb_apb_uart_slave_if;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, write_data_in, config_address, read_data;
  logic        PREADY, PSLVERR, TX_detect, RX_detect, config_write_detect, config_read_detect;
  logic        ready, error;

  int n_cmp  = 0;
  int n_fail = 0;
  int det_cycles = 0;
  bit mon_en = 0;

  logic [3:0] w_det;
  assign w_det = {TX_detect, RX_detect, config_write_detect, config_read_detect};

  apb_uart_slave_if #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .write_data_in(write_data_in), .config_address(config_address),
    .TX_detect(TX_detect), .RX_detect(RX_detect),
    .config_write_detect(config_write_detect), .config_read_detect(config_read_detect),
    .read_data(read_data), .ready(ready), .error(error)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (mon_en) begin
      if (|w_det) det_cycles++;
      check("onehot_detects", 64'($onehot0(w_det)), 64'd1);
    end
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // SETUP edge then ACCESS edge; returns just after the edge that samples ACCESS.
  task automatic apb_access(input logic [31:0] a, input logic w, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
    tick;
    PENABLE = 1'b1;
    tick;
  endtask

  task automatic apb_end;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  int n_hi, n_rdy, base;

  initial begin
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    read_data = 0; ready = 0; error = 0; PRESETn = 0;
    tick; tick;
    check("rst_pready",  64'(PREADY), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_prdata",  64'(PRDATA), 64'd0);
    check("rst_detects", 64'(w_det), 64'd0);
    check("rst_addr",    64'(config_address), 64'd0);
    check("rst_wdata",   64'(write_data_in), 64'd0);
    PRESETn = 1; mon_en = 1;

    // Baud write: 2 wait states, ready ignored on the first DRIVE edge
    PSEL = 1; PENABLE = 0; PADDR = 32'h08; PWRITE = 1; PWDATA = 32'd115200;
    tick;
    check("setup_no_det", 64'(w_det), 64'd0);
    PENABLE = 1;
    tick;
    check("baud_det",   64'(w_det), 64'b0010);
    check("baud_addr",  64'(config_address), 64'h08);
    check("baud_wdata", 64'(write_data_in), 64'd115200);
    check("baud_wait1", 64'(PREADY), 64'd0);
    ready = 1;
    tick;
    check("baud_det_hold", 64'(w_det), 64'b0010);
    check("baud_wait2",    64'(PREADY), 64'd0);
    tick;
    check("baud_pready",  64'(PREADY), 64'd1);
    check("baud_pslverr", 64'(PSLVERR), 64'd0);
    check("baud_det_off", 64'(w_det), 64'd0);
    check("baud_prdata",  64'(PRDATA), 64'd0);
    apb_end; ready = 0;
    tick;
    check("baud_pready_off", 64'(PREADY), 64'd0);

    // Frame read returning 8
    read_data = 32'd8;
    apb_access(32'h0C, 1'b0, 32'd0);
    check("frame_det", 64'(w_det), 64'b0001);
    check("frame_prdata_drive", 64'(PRDATA), 64'd0);
    ready = 1;
    tick; tick;
    check("frame_pready",  64'(PREADY), 64'd1);
    check("frame_pslverr", 64'(PSLVERR), 64'd0);
    check("frame_prdata",  64'(PRDATA), 64'd8);
    apb_end; ready = 0;
    tick;
    check("frame_prdata_off", 64'(PRDATA), 64'd0);
    check("frame_pready_off", 64'(PREADY), 64'd0);

`ifndef APB_UART_TIMEOUT_EN
    // TX write with core ready delayed 500 cycles
    apb_access(32'h00, 1'b1, 32'h55);
    check("tx_det",   64'(w_det), 64'b1000);
    check("tx_wdata", 64'(write_data_in), 64'h55);
    n_hi = 0; n_rdy = 0;
    repeat (500) begin
      tick;
      if (TX_detect) n_hi++;
      if (PREADY) n_rdy++;
    end
    check("tx_hold_cycles", 64'(n_hi), 64'd500);
    check("tx_no_early_pready", 64'(n_rdy), 64'd0);
    ready = 1;
    tick;
    check("tx_pready",  64'(PREADY), 64'd1);
    check("tx_pslverr", 64'(PSLVERR), 64'd0);
    check("tx_det_off", 64'(w_det), 64'd0);
    apb_end; ready = 0;
    tick;
    check("tx_pready_one_cycle", 64'(PREADY), 64'd0);
`else
    // Watchdog: ready never comes; TX_detect stays 16 DRIVE cycles then an error response
    apb_access(32'h00, 1'b1, 32'h55);
    check("to_det", 64'(w_det), 64'b1000);
    n_hi = 1; n_rdy = 0;
    repeat (15) begin
      tick;
      if (TX_detect) n_hi++;
      if (PREADY) n_rdy++;
    end
    check("to_hold_cycles", 64'(n_hi), 64'd16);
    check("to_no_early_pready", 64'(n_rdy), 64'd0);
    tick;
    check("to_det_off", 64'(w_det), 64'd0);
    check("to_pready",  64'(PREADY), 64'd1);
    check("to_pslverr", 64'(PSLVERR), 64'd1);
    check("to_prdata",  64'(PRDATA), 64'd0);
    apb_end;
    tick;
    check("to_pready_off", 64'(PREADY), 64'd0);
`endif

    // TX write with core error at ready
    apb_access(32'h00, 1'b1, 32'hAA);
    ready = 1; error = 1;
    tick; tick;
    check("txerr_pready",  64'(PREADY), 64'd1);
    check("txerr_pslverr", 64'(PSLVERR), 64'd1);
    apb_end; ready = 0; error = 0;
    tick;
    check("txerr_pslverr_off", 64'(PSLVERR), 64'd0);

    // Unmapped read then write to RX: error response, no detect ever
    base = det_cycles;
    read_data = 32'hDEAD;
    apb_access(32'h40, 1'b0, 32'd0);
    check("unmap_pready",  64'(PREADY), 64'd1);
    check("unmap_pslverr", 64'(PSLVERR), 64'd1);
    check("unmap_prdata",  64'(PRDATA), 64'd0);
    apb_end;
    tick;
    check("unmap_pready_off", 64'(PREADY), 64'd0);
    apb_access(32'h04, 1'b1, 32'h12);
    check("rxwr_pready",  64'(PREADY), 64'd1);
    check("rxwr_pslverr", 64'(PSLVERR), 64'd1);
    check("rxwr_prdata",  64'(PRDATA), 64'd0);
    apb_end;
    tick;
    check("rxwr_pready_off", 64'(PREADY), 64'd0);
    check("err_no_detect", 64'(det_cycles - base), 64'd0);

    // Master drops PSEL during DRIVE
    apb_access(32'h10, 1'b1, 32'd1);
    check("drop_det", 64'(w_det), 64'b0010);
    apb_end;
    tick;
    check("drop_det_off", 64'(w_det), 64'd0);
    check("drop_no_pready", 64'(PREADY), 64'd0);
    tick;
    check("drop_no_pready2", 64'(PREADY), 64'd0);

    // Reset mid-DRIVE on an RX read, then a normal RX read
    apb_access(32'h04, 1'b0, 32'd0);
    check("rxrst_det", 64'(w_det), 64'b0100);
    tick; tick;
    check("rxrst_det_hold", 64'(w_det), 64'b0100);
    PRESETn = 0;
    tick;
    check("rxrst_detects", 64'(w_det), 64'd0);
    check("rxrst_pready",  64'(PREADY), 64'd0);
    check("rxrst_pslverr", 64'(PSLVERR), 64'd0);
    check("rxrst_prdata",  64'(PRDATA), 64'd0);
    check("rxrst_addr",    64'(config_address), 64'd0);
    check("rxrst_wdata",   64'(write_data_in), 64'd0);
    PRESETn = 1; apb_end;
    tick;
    check("rxrst_no_pready", 64'(PREADY), 64'd0);
    read_data = 32'hA5;
    apb_access(32'h04, 1'b0, 32'd0);
    check("rx_det", 64'(w_det), 64'b0100);
    ready = 1;
    tick; tick;
    check("rx_pready",  64'(PREADY), 64'd1);
    check("rx_pslverr", 64'(PSLVERR), 64'd0);
    check("rx_prdata",  64'(PRDATA), 64'hA5);
    apb_end; ready = 0;
    tick;
    check("rx_pready_off", 64'(PREADY), 64'd0);

    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
